// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the PC, issues one fetch at a time to a multi-cycle instruction
// memory and holds the returned word in a one-entry slot until decode consumes it.
module fetch_seq #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  input  logic        mem_stall,
  input  logic        mem_done,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc_curr,
  output logic [15:0] pc_inc,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] instr_q;
  logic [15:0] pc_curr_q;
  logic        instr_valid_q;
  logic        halt_pend_q;

  logic slot_free;
  logic consume;
  logic mem_en_w;
  logic accept;

  assign slot_free = !instr_valid_q || !stall_in;
  assign consume   = instr_valid_q && !stall_in;

  // rst gates the request combinationally so an asserted reset never leaks a fetch.
  assign mem_en_w = rst && (state_q == ST_FETCH) && slot_free && !redirect && !halt;
  assign accept   = mem_en_w && !mem_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      pc_curr_q     <= RESET_PC;
      instr_valid_q <= 1'b0;
      halt_pend_q   <= 1'b0;
    end else if (redirect && (state_q != ST_HALT)) begin
      // A response still owed to the squashed path must be drained before refetching.
      pc_q          <= redirect_pc;
      instr_q       <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      halt_pend_q   <= 1'b0;
      if (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !mem_done)
        state_q <= ST_DRAIN;
      else
        state_q <= ST_FETCH;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (halt) begin
            state_q       <= ST_HALT;
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
            halt_pend_q   <= 1'b0;
          end else begin
            if (consume) begin
              instr_q       <= NOP_INSTR;
              instr_valid_q <= 1'b0;
            end
            if (accept) begin
              if (mem_done) begin
                instr_q       <= mem_data;
                instr_valid_q <= 1'b1;
                pc_curr_q     <= pc_q;
                pc_q          <= pc_q + 16'd2;
              end else begin
                state_q <= ST_WAIT;
              end
            end
          end
        end
        ST_WAIT: begin
          if (halt) begin
            if (mem_done) begin
              state_q       <= ST_HALT;
              instr_q       <= NOP_INSTR;
              instr_valid_q <= 1'b0;
              halt_pend_q   <= 1'b0;
            end else begin
              halt_pend_q <= 1'b1;
              state_q     <= ST_DRAIN;
            end
          end else begin
            if (consume) begin
              instr_q       <= NOP_INSTR;
              instr_valid_q <= 1'b0;
            end
            if (mem_done) begin
              instr_q       <= mem_data;
              instr_valid_q <= 1'b1;
              pc_curr_q     <= pc_q;
              pc_q          <= pc_q + 16'd2;
              state_q       <= ST_FETCH;
            end
          end
        end
        ST_DRAIN: begin
          if (mem_done) begin
            halt_pend_q <= 1'b0;
            if (halt_pend_q || halt) begin
              state_q       <= ST_HALT;
              instr_q       <= NOP_INSTR;
              instr_valid_q <= 1'b0;
            end else begin
              state_q <= ST_FETCH;
              if (consume) begin
                instr_q       <= NOP_INSTR;
                instr_valid_q <= 1'b0;
              end
            end
          end else if (halt) begin
            halt_pend_q <= 1'b1;
          end else if (consume) begin
            instr_q       <= NOP_INSTR;
            instr_valid_q <= 1'b0;
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_FETCH;
        end
      endcase
    end
  end

  assign mem_en      = mem_en_w;
  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign pc_curr     = pc_curr_q;
  assign pc_inc      = pc_curr_q + 16'd2;
  assign halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: hits, miss, decode stall, redirect drain, wrap, halt, reset.
module tb_fetch_seq;

  logic        clk;
  logic        rst;
  logic        stall_in;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        mem_stall;
  logic        mem_done;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_curr;
  logic [15:0] pc_inc;
  logic        halted;

  int total_cnt = 0;
  int bad_cnt   = 0;

  fetch_seq dut (
    .clk         (clk),
    .rst         (rst),
    .stall_in    (stall_in),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .mem_en      (mem_en),
    .mem_addr    (mem_addr),
    .mem_stall   (mem_stall),
    .mem_done    (mem_done),
    .mem_data    (mem_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_curr     (pc_curr),
    .pc_inc      (pc_inc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are then changed and given 1ns to settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b0;
    stall_in    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt        = 1'b0;
    mem_stall   = 1'b0;
    mem_done    = 1'b0;
    mem_data    = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_en", mem_en, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 16'h0800);
    chk("rst_pc_curr", pc_curr, 16'h0000);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_halted", halted, 0);
    rst = 1'b1;

    // zero-wait hits at pc 0,2,4
    mem_done = 1'b1; mem_data = 16'h1111; #1;
    chk("hit0_en", mem_en, 1);
    chk("hit0_addr", mem_addr, 16'h0000);
    step();
    chk("hit0_instr", instr, 16'h1111);
    chk("hit0_valid", instr_valid, 1);
    chk("hit0_pc", pc_curr, 16'h0000);
    chk("hit0_inc", pc_inc, 16'h0002);
    mem_data = 16'h2222; #1;
    chk("hit1_en", mem_en, 1);
    step();
    chk("hit1_instr", instr, 16'h2222);
    chk("hit1_pc", pc_curr, 16'h0002);
    chk("hit1_inc", pc_inc, 16'h0004);
    mem_data = 16'h3333;
    step();
    chk("hit2_instr", instr, 16'h3333);
    chk("hit2_valid", instr_valid, 1);
    chk("hit2_pc", pc_curr, 16'h0004);
    chk("hit2_inc", pc_inc, 16'h0006);

    // redirect from FETCH to 0x0010: one bubble, no request that cycle
    mem_done = 1'b0; redirect = 1'b1; redirect_pc = 16'h0010; #1;
    chk("redir_en", mem_en, 0);
    step();
    redirect = 1'b0; #1;
    chk("redir_valid", instr_valid, 0);
    chk("redir_instr", instr, 16'h0800);
    chk("redir_addr", mem_addr, 16'h0010);

    // miss: two stall cycles, then response three cycles after accept
    mem_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("miss_stall_en", mem_en, 1);
      chk("miss_stall_addr", mem_addr, 16'h0010);
      step();
    end
    mem_stall = 1'b0; #1;
    chk("miss_acc_en", mem_en, 1);
    step();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("miss_wait_en", mem_en, 0);
      chk("miss_wait_addr", mem_addr, 16'h0010);
      step();
    end
    mem_done = 1'b1; mem_data = 16'h4444; #1;
    chk("miss_done_en", mem_en, 0);
    step();
    mem_done = 1'b0; #1;
    chk("miss_instr", instr, 16'h4444);
    chk("miss_pc", pc_curr, 16'h0010);
    chk("miss_addr", mem_addr, 16'h0012);
    chk("miss_valid", instr_valid, 1);

    // decode stall holds the slot and blocks new requests
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dst_en", mem_en, 0);
      chk("dst_instr", instr, 16'h4444);
      chk("dst_pc", pc_curr, 16'h0010);
      step();
    end
    stall_in = 1'b0; mem_done = 1'b1; mem_data = 16'h5555; #1;
    chk("dst_rel_en", mem_en, 1);
    chk("dst_rel_addr", mem_addr, 16'h0012);
    step();
    mem_done = 1'b0; #1;
    chk("dst_instr2", instr, 16'h5555);
    chk("dst_pc2", pc_curr, 16'h0012);

    // redirect while WAIT: stale response dropped in DRAIN
    chk("rw_acc_en", mem_en, 1);
    step();
    chk("rw_wait_valid", instr_valid, 0);
    redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0; #1;
    chk("rw_drain_en", mem_en, 0);
    chk("rw_drain_valid", instr_valid, 0);
    chk("rw_drain_addr", mem_addr, 16'h0100);
    mem_done = 1'b1; mem_data = 16'hDEAD;
    step();
    mem_done = 1'b0; #1;
    chk("rw_drop_valid", instr_valid, 0);
    chk("rw_drop_instr", instr, 16'h0800);
    chk("rw_refetch_en", mem_en, 1);
    chk("rw_refetch_addr", mem_addr, 16'h0100);
    mem_done = 1'b1; mem_data = 16'h6666;
    step();
    mem_done = 1'b0; #1;
    chk("rw_instr", instr, 16'h6666);
    chk("rw_pc", pc_curr, 16'h0100);

    // wrap at 0xFFFE
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0; mem_done = 1'b1; mem_data = 16'h7777; #1;
    chk("wrap_addr0", mem_addr, 16'hFFFE);
    step();
    mem_done = 1'b0; #1;
    chk("wrap_pc", pc_curr, 16'hFFFE);
    chk("wrap_inc", pc_inc, 16'h0000);
    chk("wrap_addr1", mem_addr, 16'h0000);

    // redirect and halt together: redirect wins
    redirect = 1'b1; redirect_pc = 16'h0200; halt = 1'b1;
    step();
    redirect = 1'b0; halt = 1'b0; #1;
    chk("rh_halted", halted, 0);
    chk("rh_addr", mem_addr, 16'h0200);

    // halt with a fetch outstanding
    chk("hlt_acc_en", mem_en, 1);
    step();
    halt = 1'b1; #1;
    chk("hlt_wait_en", mem_en, 0);
    step();
    chk("hlt_drain_halted", halted, 0);
    mem_done = 1'b1; mem_data = 16'hBEEF;
    step();
    mem_done = 1'b0; halt = 1'b0; #1;
    chk("hlt_halted", halted, 1);
    chk("hlt_valid", instr_valid, 0);
    chk("hlt_instr", instr, 16'h0800);
    for (int i = 0; i < 22; i++) begin
      #1;
      chk("hlt_idle_en", mem_en, 0);
      step();
    end
    chk("hlt_still", halted, 1);

    // reset exits HALT
    rst = 1'b0; #1;
    chk("rst2_en", mem_en, 0);
    chk("rst2_halted", halted, 0);
    chk("rst2_addr", mem_addr, 16'h0000);
    step();
    rst = 1'b1; #1;
    chk("rst2_fetch_en", mem_en, 1);
    step();
    // mid-transaction reset abandons the outstanding fetch
    rst = 1'b0; #1;
    chk("rst3_en", mem_en, 0);
    chk("rst3_addr", mem_addr, 16'h0000);
    step();
    rst = 1'b1; mem_done = 1'b1; mem_data = 16'h8888; #1;
    chk("rst3_fetch_en", mem_en, 1);
    step();
    mem_done = 1'b0; #1;
    chk("rst3_instr", instr, 16'h8888);
    chk("rst3_pc", pc_curr, 16'h0000);
    chk("rst3_inc", pc_inc, 16'h0002);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
